// File: rtl/toggle_pkg.sv
// Shared constants and output-state encoding for the toggle line-code decoder.
package toggle_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_CNT_W = $clog2(DEF_WIDTH);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_t;

endpackage

// File: rtl/toggle_sync.sv
// Two-flop synchroniser for one asynchronous level, reset to 0.
module toggle_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/toggle_decoder.sv
// Toggle line-code receiver: recovers t = q_in ^ q_prev on each strobe, packs words MSB-first.
// Define TOGGLE_DECODER_SYNC_EN to pass q_in/bit_en through 2-flop synchronisers (+2 cycles).
module toggle_decoder
    import toggle_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             q_in,
    input  logic             bit_en,
    input  logic             clr,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             overrun
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    logic q_s;
    logic en_s;

`ifdef TOGGLE_DECODER_SYNC_EN
    toggle_sync u_sync_q (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (q_in),
        .q     (q_s)
    );

    toggle_sync u_sync_en (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bit_en),
        .q     (en_s)
    );
`else
    assign q_s  = q_in;
    assign en_s = bit_en;
`endif

    logic             q_prev;
    logic [WIDTH-2:0] shift;
    logic [CNT_W-1:0] bit_cnt;
    out_state_t       state;

    logic             t_rec;
    logic             word_done;
    logic             accept;
    logic [WIDTH-1:0] word;

    assign t_rec      = q_s ^ q_prev;
    assign word_done  = en_s && (bit_cnt == CNT_W'(WIDTH - 1));
    assign word       = {shift, t_rec};
    assign accept     = (state == ST_FULL) && data_ready;
    assign data_valid = (state == ST_FULL);

    // Bit recovery, word packing and EMPTY/FULL holding register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_prev   <= 1'b0;
            shift    <= '0;
            bit_cnt  <= '0;
            data_out <= '0;
            state    <= ST_EMPTY;
            overrun  <= 1'b0;
        end else if (clr) begin
            q_prev  <= q_s;
            shift   <= '0;
            bit_cnt <= '0;
            state   <= ST_EMPTY;
            overrun <= 1'b0;
        end else begin
            if (en_s) begin
                q_prev  <= q_s;
                shift   <= word[WIDTH-2:0];
                bit_cnt <= word_done ? '0 : bit_cnt + CNT_W'(1);
            end
            // A completed word is loaded if the register is free this edge, otherwise dropped.
            if (word_done) begin
                if ((state == ST_EMPTY) || accept) begin
                    data_out <= word;
                    state    <= ST_FULL;
                end else begin
                    overrun  <= 1'b1;
                end
            end else if (accept) begin
                state <= ST_EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_toggle_decoder.sv
// Directed bench for toggle_decoder; transmitter is a T flip-flop level tx_q driven onto q_in.
module tb_toggle_decoder;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         q_in;
    logic         bit_en;
    logic         clr;
    logic [W-1:0] data_out;
    logic         data_valid;
    logic         data_ready;
    logic         overrun;

    logic         tx_q;
    int           n_pass = 0;
    int           n_total = 0;

    toggle_decoder #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .q_in       (q_in),
        .bit_en     (bit_en),
        .clr        (clr),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // T flip-flop transmitter: toggles its level when t=1, then strobes one bit.
    task automatic send_bit(input logic t);
        tx_q   = tx_q ^ t;
        q_in   = tx_q;
        bit_en = 1'b1;
        step();
        bit_en = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; q_in = 1'b0; bit_en = 1'b0; clr = 1'b0; data_ready = 1'b0; tx_q = 1'b0;
        #2;
        n_total++;
        if ({data_out, data_valid, overrun} !== {8'h00, 1'b0, 1'b0})
            $display("FAIL reset: out=%h valid=%b ovr=%b, want 00/0/0", data_out, data_valid, overrun);
        else n_pass++;
        step(); step();
        rst_n = 1'b1;
        q_in  = 1'b1;
        repeat (3) step();
        n_total++;
        if ({data_out, data_valid, overrun} !== {8'h00, 1'b0, 1'b0})
            $display("FAIL idle_after_reset: out=%h valid=%b ovr=%b, want 00/0/0", data_out, data_valid, overrun);
        else n_pass++;
        q_in = tx_q;
    endtask

    task automatic test_basic();
        logic [W-1:0] w;
        logic bad_early;
        w = 8'hB2;
        bad_early = 1'b0;
        data_ready = 1'b1;
        for (int i = W - 1; i >= 0; i--) begin
            send_bit(w[i]);
            if (i != 0 && data_valid !== 1'b0) bad_early = 1'b1;
        end
        n_total++;
        if (bad_early) $display("FAIL basic_early_valid: valid rose before last bit, want 0");
        else n_pass++;
        n_total++;
        if (data_out !== 8'hB2 || data_valid !== 1'b1)
            $display("FAIL basic_word: out=%h valid=%b, want b2/1", data_out, data_valid);
        else n_pass++;
        step();
        n_total++;
        if (data_valid !== 1'b0 || overrun !== 1'b0 || data_out !== 8'hB2)
            $display("FAIL basic_one_cycle: valid=%b ovr=%b out=%h, want 0/0/b2", data_valid, overrun, data_out);
        else n_pass++;
    endtask

    task automatic test_overrun();
        data_ready = 1'b0;
        send_word(8'hB2);
        n_total++;
        if (data_out !== 8'hB2 || data_valid !== 1'b1 || overrun !== 1'b0)
            $display("FAIL ovr_first: out=%h valid=%b ovr=%b, want b2/1/0", data_out, data_valid, overrun);
        else n_pass++;
        send_word(8'h0F);
        n_total++;
        if (data_out !== 8'hB2 || data_valid !== 1'b1 || overrun !== 1'b1)
            $display("FAIL ovr_second: out=%h valid=%b ovr=%b, want b2/1/1", data_out, data_valid, overrun);
        else n_pass++;
        data_ready = 1'b1;
        step();
        n_total++;
        if (data_out !== 8'hB2 || data_valid !== 1'b0 || overrun !== 1'b1)
            $display("FAIL ovr_accept: out=%h valid=%b ovr=%b, want b2/0/1", data_out, data_valid, overrun);
        else n_pass++;
        clr  = 1'b1;
        q_in = tx_q;
        step();
        clr = 1'b0;
        n_total++;
        if (overrun !== 1'b0 || data_valid !== 1'b0)
            $display("FAIL ovr_clr: ovr=%b valid=%b, want 0/0", overrun, data_valid);
        else n_pass++;
    endtask

    task automatic test_sparse_strobe();
        logic [W-1:0] w;
        w = 8'h3C;
        data_ready = 1'b1;
        for (int i = W - 1; i >= 0; i--) begin
            // Line noise between strobes must be ignored.
            q_in = ~tx_q; step();
            q_in = tx_q;  step();
            send_bit(w[i]);
        end
        n_total++;
        if (data_out !== 8'h3C || data_valid !== 1'b1)
            $display("FAIL sparse_word: out=%h valid=%b, want 3c/1", data_out, data_valid);
        else n_pass++;
        step();
    endtask

    task automatic test_reset_midword();
        data_ready = 1'b1;
        repeat (4) send_bit(1'b1);
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({data_out, data_valid, overrun} !== {8'h00, 1'b0, 1'b0})
            $display("FAIL midword_reset: out=%h valid=%b ovr=%b, want 00/0/0", data_out, data_valid, overrun);
        else n_pass++;
        tx_q = 1'b0;
        q_in = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        send_word(8'hA5);
        n_total++;
        if (data_out !== 8'hA5 || data_valid !== 1'b1)
            $display("FAIL midword_fresh: out=%h valid=%b, want a5/1", data_out, data_valid);
        else n_pass++;
        step();
    endtask

    task automatic test_clr_midword();
        logic [W-1:0] w;
        logic bad_early;
        data_ready = 1'b0;
        send_word(8'h11);
        send_word(8'h22);
        n_total++;
        if (overrun !== 1'b1 || data_out !== 8'h11)
            $display("FAIL clr_setup: ovr=%b out=%h, want 1/11", overrun, data_out);
        else n_pass++;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        // Clear with a strobe in the same cycle; the line moves to a new reference level.
        tx_q   = ~tx_q;
        q_in   = tx_q;
        clr    = 1'b1;
        bit_en = 1'b1;
        step();
        clr    = 1'b0;
        bit_en = 1'b0;
        n_total++;
        if (data_valid !== 1'b0 || overrun !== 1'b0 || data_out !== 8'h11)
            $display("FAIL clr_state: valid=%b ovr=%b out=%h, want 0/0/11", data_valid, overrun, data_out);
        else n_pass++;
        data_ready = 1'b1;
        w = 8'h5A;
        bad_early = 1'b0;
        for (int i = W - 1; i >= 0; i--) begin
            send_bit(w[i]);
            if (i != 0 && data_valid !== 1'b0) bad_early = 1'b1;
        end
        n_total++;
        if (bad_early) $display("FAIL clr_bitcnt: word completed early after clr, want full 8 bits");
        else n_pass++;
        n_total++;
        if (data_out !== 8'h5A || data_valid !== 1'b1)
            $display("FAIL clr_word: out=%h valid=%b, want 5a/1", data_out, data_valid);
        else n_pass++;
        step();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_sparse_strobe();
        test_reset_midword();
        test_clr_midword();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
